mont_adder_seq: RTL

- Controller that drives the mpadder carry-save accumulator interface from the initiator side.
- Runs a bit-serial, LSB-first Montgomery product R = A·B·2^-N mod M; the result is left un-reduced, R < 2M.
- Issues per-cycle operands with enableC/shift, then steps the carry-resolution selector (codes 0..4, idle 8) until cZero.
- Sits between the top-level exponentiation control and one mpadder instance.

---
 rtl/mont_pkg.sv | 20 ++
 rtl/mont_res_stepper.sv | 51 +++++
 rtl/mont_adder_seq.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/mont_pkg.sv
// mont_pkg: shared state type and constants for the
// bit-serial Montgomery controller and its selector stepper.
package mont_pkg;

  localparam int MONT_N = 512;

  localparam logic [3:0] SEL_IDLE = 4'd8;
  localparam logic [3:0] SEL_LAST = 4'd4;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ADDB,
    ADDM,
    RES,
    CAPT,
    DONE
  } state_t;

endpackage

// File: rtl/mont_res_stepper.sv
// mont_res_stepper: walks the carry-resolution selector 0..4
// once per go pulse and counts completed resolution passes.
module mont_res_stepper
  import mont_pkg::*;
#(
  parameter int MAX_PASSES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       go,
  input  logic       czero,
  output logic [3:0] sel,
  output logic       last,
  output logic       passes_exhausted
);

  localparam int PW = $clog2(MAX_PASSES + 1);

  logic [3:0]    r_sel;
  logic [PW-1:0] r_passes;

  // Selector sequence plus pass counter; a pass ends on code 4.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sel    <= SEL_IDLE;
      r_passes <= '0;
    end else begin
      if (clr)
        r_passes <= '0;
      else if (r_sel == SEL_LAST)
        r_passes <= r_passes + PW'(1);

      if (go)
        r_sel <= 4'd0;
      else if (r_sel == SEL_LAST)
        r_sel <= SEL_IDLE;
      else if (r_sel != SEL_IDLE)
        r_sel <= r_sel + 4'd1;
    end
  end

  assign sel  = r_sel;
  assign last = (r_sel == SEL_LAST);

  // Only meaningful in the capture cycle: no zero carry
  // and no retries left.
  assign passes_exhausted =
    !czero && (r_passes >= PW'(MAX_PASSES));

endmodule

// File: rtl/mont_adder_seq.sv
// mont_adder_seq: drives an mpadder carry-save accumulator to
// compute A*B*2^-N mod M (un-reduced, < 2M) bit-serially.
module mont_adder_seq
  import mont_pkg::*;
#(
  parameter int N          = MONT_N,
  parameter int MAX_PASSES = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] m,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [N+1:0] result,
  output logic         add_resetn,
  output logic [N+1:0] add_in_a,
  output logic         add_subtract,
  output logic         add_shift,
  output logic         add_enableC,
  output logic [3:0]   add_sel,
  input  logic [N+2:0] add_result,
  input  logic         add_czero
);

  localparam int IW = $clog2(N);

  state_t        r_state;
  logic [N-1:0]  r_a;
  logic [N-1:0]  r_b;
  logic [N-1:0]  r_m;
  logic [IW-1:0] r_i;
  logic          r_busy;
  logic          r_done;
  logic          r_err;
  logic          r_resetn;
  logic          r_shift;
  logic          r_enc;
  logic          r_addm;
  logic [N+1:0]  r_result;
  logic [N+1:0]  r_inb;

  logic          w_go;
  logic          w_clr;
  logic          w_last;
  logic          w_exh;
  logic [3:0]    w_sel;
  logic [N+1:0]  w_next_b;
  logic [N+1:0]  w_m_add;
  logic          w_last_bit;
  logic          w_unused_msb;

  assign w_last_bit = (r_i == IW'(N - 1));
  assign w_next_b   = r_a[0] ? {2'b00, r_b} : '0;

  // The reduction multiple depends on the accumulator parity
  // right after the B add has landed, so it is gated here.
  assign w_m_add = (r_addm && add_result[0]) ?
                   {2'b00, r_m} : '0;

  assign w_clr = (r_state == IDLE) && start;
  assign w_go  = ((r_state == ADDM) && w_last_bit) ||
                 ((r_state == CAPT) && !add_czero && !w_exh);

  assign w_unused_msb = add_result[N+2];

  mont_res_stepper #(
    .MAX_PASSES(MAX_PASSES)
  ) u_step (
    .clk             (clk),
    .reset           (reset),
    .clr             (w_clr),
    .go              (w_go),
    .czero           (add_czero),
    .sel             (w_sel),
    .last            (w_last),
    .passes_exhausted(w_exh)
  );

  // Main sequencer with registered adder controls.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_i      <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_resetn <= 1'b1;
      r_shift  <= 1'b0;
      r_enc    <= 1'b0;
      r_addm   <= 1'b0;
      r_result <= '0;
      r_inb    <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_a      <= a;
            r_b      <= b;
            r_m      <= m;
            r_err    <= 1'b0;
            r_i      <= '0;
            r_busy   <= 1'b1;
            r_resetn <= 1'b0;
            r_state  <= CLEAR;
          end
        end
        CLEAR: begin
          r_resetn <= 1'b1;
          r_enc    <= 1'b1;
          r_shift  <= 1'b0;
          r_inb    <= w_next_b;
          r_a      <= r_a >> 1;
          r_state  <= ADDB;
        end
        ADDB: begin
          r_shift <= 1'b1;
          r_inb   <= '0;
          r_addm  <= 1'b1;
          r_state <= ADDM;
        end
        ADDM: begin
          r_addm  <= 1'b0;
          r_shift <= 1'b0;
          if (w_last_bit) begin
            r_enc   <= 1'b0;
            r_state <= RES;
          end else begin
            r_i     <= r_i + IW'(1);
            r_inb   <= w_next_b;
            r_a     <= r_a >> 1;
            r_state <= ADDB;
          end
        end
        RES: begin
          if (w_last)
            r_state <= CAPT;
        end
        CAPT: begin
          if (add_czero || w_exh) begin
            r_result <= add_result[N+1:0];
            r_err    <= !add_czero;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= DONE;
          end else begin
            r_state <= RES;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign err          = r_err;
  assign result       = r_result;
  assign add_resetn   = r_resetn;
  assign add_in_a     = r_inb | w_m_add;
  assign add_subtract = 1'b0;
  assign add_shift    = r_shift;
  assign add_enableC  = r_enc;
  assign add_sel      = w_sel;

endmodule
